// File: rtl/z_stream_packer_pkg.sv
// Shared types and defaults for the z-stream packer (state encoding, default widths, index width helper).
package z_packer_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_CNT_W  = 16;

  function automatic int idx_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/z_stream_packer_shifter.sv
// z_bit_shifter: LSB-first serial-to-parallel collector; presents the completed word
// combinationally together with a one-cycle word_done on the accepting edge.
module z_bit_shifter
  import z_packer_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              z_in,
  input  logic              z_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int IDX_W = idx_w(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [IDX_W-1:0]  bit_idx_p0;
  logic [WORD_W-1:0] shift_p0;

  // The word includes the bit being accepted this edge so the top can load it without a bubble.
  always_comb begin
    word             = shift_p0;
    word[bit_idx_p0] = z_in;
    word_done        = z_valid && (bit_idx_p0 == LAST_IDX);
  end

  // p0: accept stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_idx_p0 <= '0;
      shift_p0   <= '0;
    end else if (z_valid) begin
      if (bit_idx_p0 == LAST_IDX) begin
        bit_idx_p0 <= '0;
        shift_p0   <= '0;
      end else begin
        shift_p0[bit_idx_p0] <= z_in;
        bit_idx_p0           <= bit_idx_p0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/z_stream_packer.sv
// z_stream_packer: packs serial z bits into words on a valid/ready port, counts ones (saturating),
// flags dropped words. Optional parity output enabled by macro Z_PACKER_PARITY_EN.
module z_stream_packer
  import z_packer_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              z_in,
  input  logic              z_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  ones_count,
  output logic              overflow
`ifdef Z_PACKER_PARITY_EN
  ,
  output logic              word_parity
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    return (inc && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  logic [WORD_W-1:0] word_p0;
  logic              done_p0;
  state_e            state_p1;

  z_bit_shifter #(.WORD_W(WORD_W)) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .z_in      (z_in),
    .z_valid   (z_valid),
    .word      (word_p0),
    .word_done (done_p0)
  );

  assign word_valid = (state_p1 == FULL);

  // p1: output register stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_p1    <= EMPTY;
      word_out    <= '0;
      ones_count  <= '0;
      overflow    <= 1'b0;
`ifdef Z_PACKER_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      ones_count <= sat_inc(ones_count, z_valid & z_in);
      // A completing word is loaded if the register is free now or is being drained this edge.
      if (done_p0 && (state_p1 == EMPTY || word_ready)) begin
        state_p1    <= FULL;
        word_out    <= word_p0;
`ifdef Z_PACKER_PARITY_EN
        word_parity <= ^word_p0;
`endif
      end else if (done_p0) begin
        overflow <= 1'b1;
      end else if (state_p1 == FULL && word_ready) begin
        state_p1 <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_z_stream_packer.sv
// Testbench for z_stream_packer: scenario tasks with a scoreboard of expected words popped on handshakes.
module tb_z_stream_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        z_in = 1'b0;
  logic        z_valid = 1'b0;
  logic        word_ready = 1'b0;
  logic [7:0]  word_out;
  logic        word_valid;
  logic [15:0] ones_count;
  logic        overflow;
  logic [7:0]  s_word_out;
  logic        s_word_valid;
  logic [3:0]  s_ones_count;
  logic        s_overflow;
`ifdef Z_PACKER_PARITY_EN
  logic        word_parity;
  logic        s_word_parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  z_stream_packer #(.WORD_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .z_in(z_in), .z_valid(z_valid),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .ones_count(ones_count), .overflow(overflow)
`ifdef Z_PACKER_PARITY_EN
    , .word_parity(word_parity)
`endif
  );

  z_stream_packer #(.WORD_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .z_in(z_in), .z_valid(z_valid),
    .word_out(s_word_out), .word_valid(s_word_valid), .word_ready(word_ready),
    .ones_count(s_ones_count), .overflow(s_overflow)
`ifdef Z_PACKER_PARITY_EN
    , .word_parity(s_word_parity)
`endif
  );

  // Drive one clock; if a handshake happens on this edge, pop the scoreboard and compare.
  task automatic cycle(input logic zv, input logic zb, input logic rdy);
    logic       hs;
    logic [7:0] w;
    logic [7:0] exp_w;
    z_valid    = zv;
    z_in       = zb;
    word_ready = rdy;
    hs = word_valid && rdy && reset_n;
    w  = word_out;
    @(posedge clk);
    #1;
    if (hs) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_word: got %h, required no handshake", w);
      end else begin
        exp_w = sb.pop_front();
        if (w !== exp_w) begin
          errors++;
          $display("FAIL sb_word: got %h, required %h", w, exp_w);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 0; i < 8; i++) cycle(1'b1, b[i], rdy);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    checks += 5;
    if (word_out !== 8'h00)     begin errors++; $display("FAIL reset_word_out: got %h, required 00", word_out); end
    if (word_valid !== 1'b0)    begin errors++; $display("FAIL reset_word_valid: got %b, required 0", word_valid); end
    if (ones_count !== 16'd0)   begin errors++; $display("FAIL reset_ones_count: got %0d, required 0", ones_count); end
    if (overflow !== 1'b0)      begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    if (s_ones_count !== 4'd0)  begin errors++; $display("FAIL reset_ones_count_small: got %0d, required 0", s_ones_count); end
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pack(input bit gaps);
    logic [7:0] bits = 8'h4D;
    do_reset();
    sb.push_back(8'h4D);
    for (int i = 0; i < 8; i++) begin
      if (gaps) cycle(1'b0, ~bits[i], 1'b1);
      cycle(1'b1, bits[i], 1'b1);
    end
    checks += 4;
    if (word_valid !== 1'b1)  begin errors++; $display("FAIL pack_valid(gaps=%0d): got %b, required 1", gaps, word_valid); end
    if (word_out !== 8'h4D)   begin errors++; $display("FAIL pack_word(gaps=%0d): got %h, required 4d", gaps, word_out); end
    if (ones_count !== 16'd4) begin errors++; $display("FAIL pack_count(gaps=%0d): got %0d, required 4", gaps, ones_count); end
    cycle(1'b0, 1'b0, 1'b1);
    if (word_valid !== 1'b0)  begin errors++; $display("FAIL pack_valid_drop(gaps=%0d): got %b, required 0", gaps, word_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    sb.push_back(8'hFF);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h0F, 1'b0);
    checks += 4;
    if (word_out !== 8'hFF)    begin errors++; $display("FAIL ovf_word: got %h, required ff", word_out); end
    if (word_valid !== 1'b1)   begin errors++; $display("FAIL ovf_valid: got %b, required 1", word_valid); end
    if (overflow !== 1'b1)     begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    if (ones_count !== 16'd12) begin errors++; $display("FAIL ovf_count: got %0d, required 12", ones_count); end
    cycle(1'b0, 1'b0, 1'b1);
    checks += 2;
    if (word_valid !== 1'b0)   begin errors++; $display("FAIL ovf_drain_valid: got %b, required 0", word_valid); end
    if (overflow !== 1'b1)     begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b = 8'h3C;
    do_reset();
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, b[i], 1'b0);
    cycle(1'b1, b[7], 1'b1);
    checks += 3;
    if (word_out !== 8'h3C)  begin errors++; $display("FAIL b2b_word: got %h, required 3c", word_out); end
    if (word_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b, required 1", word_valid); end
    if (overflow !== 1'b0)   begin errors++; $display("FAIL b2b_overflow: got %b, required 0", overflow); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid: got %b, required 0", word_valid); end
  endtask

  task automatic test_saturation_and_midword_reset();
    do_reset();
    sb.push_back(8'hFF);
    sb.push_back(8'hFF);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1);
    checks += 2;
    if (s_ones_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d, required 15", s_ones_count); end
    if (ones_count !== 16'd20)  begin errors++; $display("FAIL wide_count: got %0d, required 20", ones_count); end
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    do_reset();
    sb.push_back(8'h4D);
    send_byte(8'h4D, 1'b0);
    checks += 2;
    if (word_out !== 8'h4D)  begin errors++; $display("FAIL midreset_word: got %h, required 4d", word_out); end
    if (ones_count !== 16'd4) begin errors++; $display("FAIL midreset_count: got %0d, required 4", ones_count); end
`ifdef Z_PACKER_PARITY_EN
    checks++;
    if (word_parity !== 1'b0) begin errors++; $display("FAIL parity_4d: got %b, required 0", word_parity); end
`endif
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_pack(1'b0);
    test_pack(1'b1);
    test_overflow();
    test_back_to_back();
    test_saturation_and_midword_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d words pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
